// File: rtl/label_char_fetch.sv
// Per-pixel character fetch for one text label per frame: maps pixels inside the
// label box to an ASCII code plus in-glyph column/row, two cycles after the pixel.
module label_char_fetch #(
  parameter int L_W   = 8,
  parameter int L_H   = 16,
  parameter int N_STR = 16,
  parameter int S_LEN = 8,
  parameter int XY_W  = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_STR*S_LEN*8-1:0]   i_str,
  input  logic                       i_vs,
  input  logic                       i_label_vld,
  input  logic [3:0]                 i_label_id,
  input  logic [XY_W-1:0]            i_label_x,
  input  logic [XY_W-1:0]            i_label_y,
  input  logic                       i_de,
  input  logic [XY_W-1:0]            i_x,
  input  logic [XY_W-1:0]            i_y,
  output logic                       o_de,
  output logic                       o_vld,
  output logic [7:0]                 o_ascii,
  output logic [$clog2(L_W)-1:0]     o_gx,
  output logic [$clog2(L_H)-1:0]     o_gy
);

  localparam int GX_W  = $clog2(L_W);
  localparam int GY_W  = $clog2(L_H);
  localparam int CC_W  = $clog2(S_LEN);
  localparam int SEL_W = $clog2(N_STR*S_LEN*8);

  typedef enum logic [1:0] {IDLE, WAIT, ROW, DONE} state_t;

  state_t            state, state_n;
  logic [3:0]        pend_id, com_id;
  logic [XY_W-1:0]   pend_x, pend_y, com_x, com_y;
  logic [XY_W-1:0]   last_y_q, last_y_n;
  logic [GY_W-1:0]   gy_q, gy_n;
  logic [GX_W-1:0]   gx_q, gx_n;
  logic [CC_W-1:0]   cc_q, cc_n;
  logic              col_on_q, col_on_n;

  logic              pix_in;
  logic [GX_W-1:0]   pix_gx;
  logic [CC_W-1:0]   pix_cc;
  logic [GY_W-1:0]   pix_gy;
  logic              row_live, col_eff, hit;

  logic              s1_de, s1_in;
  logic [GX_W-1:0]   s1_gx;
  logic [CC_W-1:0]   s1_cc;
  logic [GY_W-1:0]   s1_gy;
  logic [3:0]        s1_id;
  logic [SEL_W-1:0]  sel_base;

  logic [3:0]        new_id;
  assign new_id = i_label_vld ? i_label_id : pend_id;
  assign hit    = (i_x == com_x);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_n  = state;
    last_y_n = last_y_q;
    gy_n     = gy_q;
    gx_n     = gx_q;
    cc_n     = cc_q;
    col_on_n = col_on_q;
    pix_in   = 1'b0;
    pix_gx   = gx_q;
    pix_cc   = cc_q;
    pix_gy   = gy_q;
    row_live = 1'b0;
    col_eff  = col_on_q;

    case (state)
      WAIT: if (i_de && i_y == com_y) begin
        state_n  = ROW;
        row_live = 1'b1;
        pix_gy   = '0;
        gy_n     = '0;
        last_y_n = i_y;
        col_eff  = 1'b0;
      end
      ROW: begin
        if (i_de && i_y != last_y_q) begin
          // A new line always restarts the column run, even if the last one was cut short.
          col_eff = 1'b0;
          if (gy_q == GY_W'(L_H-1)) begin
            state_n = DONE;
          end else begin
            row_live = 1'b1;
            pix_gy   = gy_q + GY_W'(1);
            gy_n     = gy_q + GY_W'(1);
            last_y_n = i_y;
          end
        end else begin
          row_live = 1'b1;
        end
      end
      default: ;
    endcase

    col_on_n = col_eff;
    if (row_live && i_de && (hit || col_eff)) begin
      pix_in = 1'b1;
      pix_gx = hit ? '0 : gx_q;
      pix_cc = hit ? '0 : cc_q;
      if (pix_gx == GX_W'(L_W-1)) begin
        gx_n     = '0;
        cc_n     = pix_cc + CC_W'(1);
        col_on_n = (pix_cc != CC_W'(S_LEN-1));
      end else begin
        gx_n     = pix_gx + GX_W'(1);
        cc_n     = pix_cc;
        col_on_n = 1'b1;
      end
    end

    if (i_vs) begin
      state_n  = (new_id != 4'd0) ? WAIT : IDLE;
      col_on_n = 1'b0;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend_id  <= '0;
      pend_x   <= '0;
      pend_y   <= '0;
      com_id   <= '0;
      com_x    <= '0;
      com_y    <= '0;
      last_y_q <= '0;
      gy_q     <= '0;
      gx_q     <= '0;
      cc_q     <= '0;
      col_on_q <= 1'b0;
      s1_de    <= 1'b0;
      s1_in    <= 1'b0;
      s1_gx    <= '0;
      s1_cc    <= '0;
      s1_gy    <= '0;
      s1_id    <= '0;
      o_de     <= 1'b0;
      o_vld    <= 1'b0;
      o_ascii  <= '0;
      o_gx     <= '0;
      o_gy     <= '0;
    end else begin
      state    <= state_n;
      last_y_q <= last_y_n;
      gy_q     <= gy_n;
      gx_q     <= gx_n;
      cc_q     <= cc_n;
      col_on_q <= col_on_n;
      if (i_label_vld) begin
        pend_id <= i_label_id;
        pend_x  <= i_label_x;
        pend_y  <= i_label_y;
      end
      if (i_vs) begin
        com_id <= new_id;
        com_x  <= i_label_vld ? i_label_x : pend_x;
        com_y  <= i_label_vld ? i_label_y : pend_y;
      end
      s1_de <= i_de;
      s1_in <= pix_in;
      s1_gx <= pix_gx;
      s1_cc <= pix_cc;
      s1_gy <= pix_gy;
      s1_id <= com_id;
      o_de    <= s1_de;
      o_vld   <= s1_in;
      o_ascii <= s1_in ? i_str[sel_base -: 8] : 8'h00;
      o_gx    <= s1_in ? s1_gx : '0;
      o_gy    <= s1_in ? s1_gy : '0;
    end
  end

  // String 0 sits in the MSBs and char 0 is the top byte of its string.
  always_comb begin
    sel_base = SEL_W'((N_STR - int'(s1_id)) * S_LEN * 8 - 1 - 8 * int'(s1_cc));
  end

endmodule
